// File: rtl/example_hmc_prbs_pkg.sv
// Shared types and helpers for the HMC PRBS generator/checker.
package example_hmc_prbs_pkg;

    // Checker lock state machine
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_e;

    // Widest word the popcount helper handles; callers zero-extend.
    localparam int POP_W = 256;

    // Number of set bits in v
    function automatic logic [31:0] popcount(input logic [POP_W-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    // a + b clamped at max (operands assumed <= max)
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input logic [63:0] max);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[63:0];
    endfunction

endpackage

// File: rtl/example_hmc_prbs_step.sv
// One PRBS word step: from LFSR state, the DATA_WIDTH output bits and the
// state after those bits. Pure combinational.
module example_hmc_prbs_step #(
    parameter int                   DATA_WIDTH = 48,
    parameter int                   PRBS_SIZE  = 15,
    parameter logic [PRBS_SIZE-1:0] PRBS_POLY  = 15'b100000000000011
) (
    input  logic [PRBS_SIZE-1:0]  state_i,
    output logic [DATA_WIDTH-1:0] word_o,
    output logic [PRBS_SIZE-1:0]  next_o
);

    logic [PRBS_SIZE-1:0] s;

    // Unroll DATA_WIDTH serial LFSR shifts; bit i of the word is s[0] at step i
    always_comb begin
        s      = state_i;
        word_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            word_o[i] = s[0];
            s = {^(PRBS_POLY & {1'b0, s[PRBS_SIZE-2:0]}), s[PRBS_SIZE-1:1]};
        end
        next_o = s;
    end

endmodule

// File: rtl/example_hmc_prbs_engine.sv
// Registered PRBS generator (valid/ready, seed load, error injection) and
// self-seeding checker with lock FSM and saturating error counters.
module example_hmc_prbs_engine
    import example_hmc_prbs_pkg::*;
#(
    parameter int                   DATA_WIDTH = 48,
    parameter int                   PRBS_SIZE  = 15,
    parameter logic [PRBS_SIZE-1:0] PRBS_POLY  = 15'b100000000000011,
    parameter logic [PRBS_SIZE-1:0] PRBS_SEED  = {PRBS_SIZE{1'b1}},
    parameter int                   LOCK_GOOD  = 4,
    parameter int                   BAD_LIMIT  = 3,
    parameter int                   CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  gen_en_i,
    input  logic                  gen_load_i,
    input  logic [PRBS_SIZE-1:0]  gen_seed_i,
    input  logic                  gen_inj_err_i,
    output logic [DATA_WIDTH-1:0] gen_data_o,
    output logic                  gen_valid_o,
    input  logic                  gen_ready_i,
    input  logic [DATA_WIDTH-1:0] chk_data_i,
    input  logic                  chk_valid_i,
    input  logic                  chk_clear_i,
    output logic                  chk_locked_o,
    output logic [CNT_W-1:0]      chk_bit_errs_o,
    output logic [CNT_W-1:0]      chk_word_errs_o
);

    localparam int          GOOD_W  = $clog2(LOCK_GOOD + 1);
    localparam int          BAD_W   = $clog2(BAD_LIMIT + 1);
    localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // ---------------- generator ----------------
    logic [PRBS_SIZE-1:0]  gen_state_q, gen_state_d;
    logic [DATA_WIDTH-1:0] gen_data_q,  gen_data_d;
    logic                  gen_valid_q, gen_valid_d;
    logic                  inj_pend_q,  inj_pend_d;
    logic [DATA_WIDTH-1:0] gen_word;
    logic [PRBS_SIZE-1:0]  gen_next;

    example_hmc_prbs_step #(
        .DATA_WIDTH(DATA_WIDTH), .PRBS_SIZE(PRBS_SIZE), .PRBS_POLY(PRBS_POLY)
    ) u_gen_step (
        .state_i(gen_state_q), .word_o(gen_word), .next_o(gen_next)
    );

    // Generator next state: load beats produce beats drain. An injection
    // request arriving on the producing edge lands in that word.
    always_comb begin
        gen_state_d = gen_state_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = gen_valid_q;
        inj_pend_d  = inj_pend_q | gen_inj_err_i;
        if (gen_load_i) begin
            gen_state_d = (gen_seed_i == '0) ? PRBS_SEED : gen_seed_i;
            gen_valid_d = 1'b0;
            inj_pend_d  = 1'b0;
        end else if (gen_en_i && (!gen_valid_q || gen_ready_i)) begin
            gen_data_d  = gen_word ^ {{(DATA_WIDTH-1){1'b0}}, inj_pend_q | gen_inj_err_i};
            gen_state_d = gen_next;
            gen_valid_d = 1'b1;
            inj_pend_d  = 1'b0;
        end else if (!gen_en_i && gen_ready_i) begin
            gen_valid_d = 1'b0;
        end
    end

    assign gen_data_o  = gen_data_q;
    assign gen_valid_o = gen_valid_q;

    // ---------------- checker ----------------
    chk_state_e            st_q, st_d;
    logic [PRBS_SIZE-1:0]  exp_q, exp_d;
    logic [GOOD_W-1:0]     good_q, good_d;
    logic [BAD_W-1:0]      bad_q, bad_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;

    logic [DATA_WIDTH-1:0] exp_word;
    logic [PRBS_SIZE-1:0]  exp_next;
    logic [DATA_WIDTH-1:0] reseed_word_unused;
    logic [PRBS_SIZE-1:0]  reseed_next;
    logic [PRBS_SIZE-1:0]  cand;
    logic [DATA_WIDTH-1:0] diff;
    logic                  err_word;

    assign cand = chk_data_i[PRBS_SIZE-1:0];
    assign diff = chk_data_i ^ exp_word;

    example_hmc_prbs_step #(
        .DATA_WIDTH(DATA_WIDTH), .PRBS_SIZE(PRBS_SIZE), .PRBS_POLY(PRBS_POLY)
    ) u_exp_step (
        .state_i(exp_q), .word_o(exp_word), .next_o(exp_next)
    );

    // Received low bits are the LFSR state at word start, so stepping them
    // once predicts the next word's state.
    example_hmc_prbs_step #(
        .DATA_WIDTH(DATA_WIDTH), .PRBS_SIZE(PRBS_SIZE), .PRBS_POLY(PRBS_POLY)
    ) u_reseed_step (
        .state_i(cand), .word_o(reseed_word_unused), .next_o(reseed_next)
    );

    // Lock FSM: self-seed in SEARCH, confirm in VERIFY, track errors in LOCKED
    always_comb begin
        st_d     = st_q;
        exp_d    = exp_q;
        good_d   = good_q;
        bad_d    = bad_q;
        err_word = 1'b0;
        if (chk_valid_i) begin
            unique case (st_q)
                SEARCH: begin
                    if (cand != '0) begin
                        exp_d  = reseed_next;
                        good_d = '0;
                        st_d   = VERIFY;
                    end
                end
                VERIFY: begin
                    if (diff == '0) begin
                        exp_d = exp_next;
                        if (good_q == GOOD_W'(LOCK_GOOD - 1)) begin
                            good_d = '0;
                            st_d   = LOCKED;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else begin
                        good_d = '0;
                        if (cand != '0) begin
                            exp_d = reseed_next;
                            st_d  = VERIFY;
                        end else begin
                            st_d  = SEARCH;
                        end
                    end
                end
                LOCKED: begin
                    exp_d = exp_next;
                    if (diff != '0) begin
                        err_word = 1'b1;
                        if (bad_q == BAD_W'(BAD_LIMIT - 1)) begin
                            bad_d = '0;
                            st_d  = SEARCH;
                        end else begin
                            bad_d = bad_q + BAD_W'(1);
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: st_d = SEARCH;
            endcase
        end
    end

    // Saturating error counters; clear wins over a same-cycle increment
    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        if (chk_clear_i) begin
            bit_cnt_d  = '0;
            word_cnt_d = '0;
        end else if (err_word) begin
            bit_cnt_d  = CNT_W'(sat_add(64'(bit_cnt_q), 64'(popcount(POP_W'(diff))), CNT_MAX));
            word_cnt_d = CNT_W'(sat_add(64'(word_cnt_q), 64'd1, CNT_MAX));
        end
    end

    assign chk_locked_o    = (st_q == LOCKED);
    assign chk_bit_errs_o  = bit_cnt_q;
    assign chk_word_errs_o = word_cnt_q;

    // All state registers, synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            gen_state_q <= PRBS_SEED;
            gen_data_q  <= '0;
            gen_valid_q <= 1'b0;
            inj_pend_q  <= 1'b0;
            st_q        <= SEARCH;
            exp_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
            inj_pend_q  <= inj_pend_d;
            st_q        <= st_d;
            exp_q       <= exp_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

endmodule

// File: tb/tb_example_hmc_prbs_engine.sv
// Bench for example_hmc_prbs_engine: generator vector table, directed
// loopback sequences and randomized traffic against a reference model.
module tb_example_hmc_prbs_engine;

    localparam int          DW    = 48;
    localparam int          PS    = 15;
    localparam logic [14:0] POLY  = 15'b100000000000011;
    localparam logic [14:0] SEED  = 15'h7fff;
    localparam int          LGOOD = 4;
    localparam int          BLIM  = 3;
    localparam longint      CMAX  = 64'h0000_0000_ffff_ffff;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          gen_en, gen_load, gen_inj, gen_ready;
    logic [PS-1:0] gen_seed;
    logic [DW-1:0] gen_data;
    logic          gen_valid;
    logic [DW-1:0] tb_cd, flip, chk_data;
    logic          tb_cv, chk_valid, chk_clear, loop_mode;
    logic          chk_locked;
    logic [31:0]   bit_errs, word_errs;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    assign chk_data  = loop_mode ? (gen_data ^ flip) : tb_cd;
    assign chk_valid = loop_mode ? (gen_valid & gen_ready) : tb_cv;

    example_hmc_prbs_engine dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .gen_en_i(gen_en), .gen_load_i(gen_load), .gen_seed_i(gen_seed),
        .gen_inj_err_i(gen_inj), .gen_data_o(gen_data), .gen_valid_o(gen_valid),
        .gen_ready_i(gen_ready),
        .chk_data_i(chk_data), .chk_valid_i(chk_valid), .chk_clear_i(chk_clear),
        .chk_locked_o(chk_locked), .chk_bit_errs_o(bit_errs), .chk_word_errs_o(word_errs)
    );

    // PRBS as a bit recurrence: b[0..14] = state, b[n+15] = xor of tapped
    // b[n+t]; a word is 48 consecutive bits, next state the 15 after them.
    function automatic void prbs_word(input logic [14:0] s, output logic [47:0] w,
                                      output logic [14:0] nx);
        bit b[63];
        for (int i = 0; i < 15; i++) b[i] = s[i];
        for (int n = 0; n < 48; n++) begin
            bit f;
            f = 1'b0;
            for (int t = 0; t < 14; t++) if (POLY[t]) f ^= b[n+t];
            b[n+15] = f;
        end
        for (int i = 0; i < 48; i++) w[i] = b[i];
        for (int i = 0; i < 15; i++) nx[i] = b[48+i];
    endfunction

    // idx-th word (0-based) of the stream started from seed
    function automatic logic [47:0] gword(input logic [14:0] seed, input int idx);
        logic [47:0] w;
        logic [14:0] s;
        s = seed;
        w = '0;
        for (int k = 0; k <= idx; k++) prbs_word(s, w, s);
        return w;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- reference model ----------------
    logic [14:0] m_gs;
    logic [47:0] m_gd;
    logic        m_gv, m_pend;
    int          m_cst;          // 0 search, 1 verify, 2 locked
    int          m_good, m_bad;
    logic [14:0] m_exp;
    longint      m_bits, m_words;

    task automatic m_reseed(input logic [47:0] cd);
        logic [47:0] w;
        logic [14:0] nx;
        m_good = 0;
        if (cd[14:0] == '0) m_cst = 0;
        else begin
            prbs_word(cd[14:0], w, nx);
            m_exp = nx;
            m_cst = 1;
        end
    endtask

    task automatic model_step();
        logic [47:0] cd, w, x;
        logic [14:0] nx;
        logic        cv;
        cd = loop_mode ? (m_gd ^ flip) : tb_cd;
        cv = loop_mode ? (m_gv & gen_ready) : tb_cv;
        if (!rst_n) begin
            m_gs = SEED; m_gd = '0; m_gv = 0; m_pend = 0;
            m_cst = 0; m_good = 0; m_bad = 0; m_exp = '0; m_bits = 0; m_words = 0;
            return;
        end
        if (cv) begin
            prbs_word(m_exp, w, nx);
            x = cd ^ w;
            if (m_cst == 0) m_reseed(cd);
            else if (m_cst == 1) begin
                if (x == '0) begin
                    m_exp = nx;
                    m_good++;
                    if (m_good == LGOOD) begin m_cst = 2; m_good = 0; end
                end else m_reseed(cd);
            end else begin
                m_exp = nx;
                if (x != '0) begin
                    if (!chk_clear) begin
                        m_bits  = (m_bits + $countones(x) > CMAX) ? CMAX : m_bits + $countones(x);
                        m_words = (m_words + 1 > CMAX) ? CMAX : m_words + 1;
                    end
                    m_bad++;
                    if (m_bad == BLIM) begin m_cst = 0; m_bad = 0; end
                end else m_bad = 0;
            end
        end
        if (chk_clear) begin m_bits = 0; m_words = 0; end
        if (gen_load) begin
            m_gs = (gen_seed == '0) ? SEED : gen_seed;
            m_gv = 0; m_pend = 0;
        end else if (gen_en && (!m_gv || gen_ready)) begin
            prbs_word(m_gs, w, nx);
            m_gd = w;
            if (m_pend || gen_inj) m_gd[0] = ~m_gd[0];
            m_gs = nx; m_gv = 1; m_pend = 0;
        end else begin
            if (gen_inj) m_pend = 1;
            if (!gen_en && gen_ready) m_gv = 0;
        end
    endtask

    // One clock: advance the model, let the DUT take the edge, compare
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("gen_valid", 64'(gen_valid), 64'(m_gv));
        check("gen_data", 64'(gen_data), 64'(m_gd));
        check("chk_locked", 64'(chk_locked), 64'(m_cst == 2));
        check("bit_errs", 64'(bit_errs), 64'(m_bits));
        check("word_errs", 64'(word_errs), 64'(m_words));
    endtask

    task automatic idle_inputs();
        gen_en = 0; gen_load = 0; gen_seed = '0; gen_inj = 0; gen_ready = 0;
        tb_cd = '0; tb_cv = 0; chk_clear = 0; loop_mode = 0; flip = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    // ---------------- generator vector table ----------------
    typedef struct {
        logic        load;
        logic [14:0] seed;
        logic        en, rdy, inj;
        logic        exp_v;
        int          exp_idx;    // -1: data still at reset value 0
        logic        exp_inj;
        logic [14:0] ref_seed;
    } gvec_t;

    function automatic gvec_t mk(input logic load, input logic [14:0] seed, input logic en,
                                 input logic rdy, input logic inj, input logic ev,
                                 input int idx, input logic einj, input logic [14:0] rs);
        gvec_t v;
        v.load = load; v.seed = seed; v.en = en; v.rdy = rdy; v.inj = inj;
        v.exp_v = ev; v.exp_idx = idx; v.exp_inj = einj; v.ref_seed = rs;
        return v;
    endfunction

    gvec_t tbl[17];

    initial begin
        int nacc;
        logic [47:0] exp_w;
        rst_n = 0;
        idle_inputs();

        tbl[0]  = mk(1, 15'h1234, 0, 0, 0, 0, -1, 0, 15'h1234);
        tbl[1]  = mk(0, 15'h0000, 1, 0, 0, 1,  0, 0, 15'h1234);
        tbl[2]  = mk(0, 15'h0000, 1, 0, 0, 1,  0, 0, 15'h1234);
        tbl[3]  = mk(0, 15'h0000, 1, 0, 0, 1,  0, 0, 15'h1234);
        tbl[4]  = mk(0, 15'h0000, 1, 1, 0, 1,  1, 0, 15'h1234);
        tbl[5]  = mk(0, 15'h0000, 1, 0, 1, 1,  1, 0, 15'h1234);
        tbl[6]  = mk(0, 15'h0000, 1, 0, 1, 1,  1, 0, 15'h1234);
        tbl[7]  = mk(0, 15'h0000, 1, 1, 0, 1,  2, 1, 15'h1234);
        tbl[8]  = mk(0, 15'h0000, 1, 1, 0, 1,  3, 0, 15'h1234);
        tbl[9]  = mk(0, 15'h0000, 0, 0, 0, 1,  3, 0, 15'h1234);
        tbl[10] = mk(0, 15'h0000, 0, 1, 0, 0,  3, 0, 15'h1234);
        tbl[11] = mk(1, 15'h0000, 1, 1, 0, 0,  3, 0, 15'h1234);
        tbl[12] = mk(0, 15'h0000, 1, 1, 0, 1,  0, 0, SEED);
        tbl[13] = mk(0, 15'h0000, 1, 1, 0, 1,  1, 0, SEED);
        tbl[14] = mk(0, 15'h0000, 0, 1, 1, 0,  1, 0, SEED);
        tbl[15] = mk(1, 15'h0055, 0, 0, 0, 0,  1, 0, SEED);
        tbl[16] = mk(0, 15'h0000, 1, 1, 0, 1,  0, 0, 15'h0055);

        // Reset state
        do_reset();
        check("rst_gen_valid", 64'(gen_valid), 64'd0);
        check("rst_gen_data", 64'(gen_data), 64'd0);
        check("rst_locked", 64'(chk_locked), 64'd0);
        check("rst_bit_errs", 64'(bit_errs), 64'd0);
        check("rst_word_errs", 64'(word_errs), 64'd0);

        // Generator handshake/load/inject table
        foreach (tbl[i]) begin
            gen_load = tbl[i].load; gen_seed = tbl[i].seed; gen_en = tbl[i].en;
            gen_ready = tbl[i].rdy; gen_inj = tbl[i].inj;
            tick();
            check($sformatf("tbl%0d_valid", i), 64'(gen_valid), 64'(tbl[i].exp_v));
            exp_w = (tbl[i].exp_idx < 0) ? 48'h0 : gword(tbl[i].ref_seed, tbl[i].exp_idx);
            exp_w[0] = exp_w[0] ^ tbl[i].exp_inj;
            check($sformatf("tbl%0d_data", i), 64'(gen_data), 64'(exp_w));
        end
        idle_inputs();

        // Loopback lock: rises after 5th accepted word, clean over 10^4 words
        do_reset();
        loop_mode = 1; gen_en = 1; gen_ready = 1;
        nacc = 0;
        for (int t = 0; t < 8; t++) begin
            if (m_gv && gen_ready) nacc++;
            tick();
            check($sformatf("lock_t%0d", t), 64'(chk_locked), 64'(nacc >= 5));
        end
        for (int t = 0; t < 10000; t++) tick();
        check("long_locked", 64'(chk_locked), 64'd1);
        check("long_bits", 64'(bit_errs), 64'd0);
        check("long_words", 64'(word_errs), 64'd0);

        // Single injected error while locked
        gen_ready = 0; gen_inj = 1; tick();
        gen_inj = 0; gen_ready = 1;
        for (int t = 0; t < 4; t++) tick();
        check("inj_bits", 64'(bit_errs), 64'd1);
        check("inj_words", 64'(word_errs), 64'd1);
        check("inj_locked", 64'(chk_locked), 64'd1);

        // Three 2-bit-errored words: lose lock, then relock 5 words later
        chk_clear = 1; tick(); chk_clear = 0;
        flip = (48'd1 << 5) | (48'd1 << 40);
        for (int t = 0; t < 3; t++) tick();
        flip = '0;
        check("burst_locked", 64'(chk_locked), 64'd0);
        check("burst_bits", 64'(bit_errs), 64'd6);
        check("burst_words", 64'(word_errs), 64'd3);
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("relock_t%0d", t), 64'(chk_locked), 64'(t == 4));
        end
        check("relock_bits", 64'(bit_errs), 64'd6);
        check("relock_words", 64'(word_errs), 64'd3);

        // Clear coincident with an errored locked word
        flip = 48'h0000_1000_0000; chk_clear = 1; tick();
        flip = '0; chk_clear = 0;
        check("clr_bits", 64'(bit_errs), 64'd0);
        check("clr_words", 64'(word_errs), 64'd0);
        check("clr_locked", 64'(chk_locked), 64'd1);

        // Reset mid-stream drops everything
        rst_n = 0; tick(); rst_n = 1;
        check("mid_rst_valid", 64'(gen_valid), 64'd0);
        check("mid_rst_data", 64'(gen_data), 64'd0);
        check("mid_rst_locked", 64'(chk_locked), 64'd0);

        // All-zero received words never leave SEARCH
        idle_inputs();
        tb_cv = 1; tb_cd = '0;
        for (int t = 0; t < 20; t++) tick();
        check("zero_locked", 64'(chk_locked), 64'd0);
        check("zero_bits", 64'(bit_errs), 64'd0);
        check("zero_words", 64'(word_errs), 64'd0);

        // Ready pattern 1,0,0,1 with backpressure
        idle_inputs();
        do_reset();
        loop_mode = 1; gen_en = 1;
        for (int r = 0; r < 12; r++) begin
            gen_ready = 1; tick();
            gen_ready = 0; tick(); tick();
            gen_ready = 1; tick();
        end
        check("stall_locked", 64'(chk_locked), 64'd1);
        check("stall_bits", 64'(bit_errs), 64'd0);
        check("stall_words", 64'(word_errs), 64'd0);

        // Randomized traffic against the model
        for (int t = 0; t < 4000; t++) begin
            gen_en    = ($urandom_range(7) != 0);
            gen_ready = ($urandom_range(3) != 0);
            gen_inj   = ($urandom_range(63) == 0);
            chk_clear = ($urandom_range(199) == 0);
            gen_load  = ($urandom_range(499) == 0);
            gen_seed  = ($urandom_range(3) == 0) ? 15'h0 : 15'($urandom);
            flip      = ($urandom_range(49) == 0) ? (48'd1 << $urandom_range(47)) |
                                                    (48'd1 << $urandom_range(47)) : 48'h0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/example_hmc_prbs_engine.md
# example_hmc_prbs_engine

Registered PRBS generator/checker pair for the HMC link test datapath. Generator streams PRBS words under valid/ready with seed load and single-bit error injection. Checker self-seeds from received data, runs a SEARCH/VERIFY/LOCKED state machine, and keeps saturating bit- and word-error counters. Both use the team's standard LFSR bit ordering, so existing combinational generators interoperate with this block.

## Interface
- DATA_WIDTH, 48: bits per word; must be ≥ PRBS_SIZE.
- PRBS_SIZE, 15: LFSR length.
- PRBS_POLY, 15'b100000000000011: feedback tap mask.
- PRBS_SEED, all ones: reset/default seed.
- LOCK_GOOD, 4: consecutive matching words in VERIFY needed to lock.
- BAD_LIMIT, 3: consecutive errored words in LOCKED that cause loss of lock.
- CNT_W, 32: error counter width.
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- gen_en  in  1  generator run enable.
- gen_load  in  1  load gen_seed into the generator LFSR.
- gen_seed  in  PRBS_SIZE  seed; zero is replaced by PRBS_SEED.
- gen_inj_err  in  1  invert bit 0 of the next generated word.
- gen_data  out  DATA_WIDTH  generated word.
- gen_valid  out  1  gen_data valid.
- gen_ready  in  1  downstream accepts gen_data.
- chk_data  in  DATA_WIDTH  received word.
- chk_valid  in  1  chk_data valid; the checker is always ready.
- chk_clear  in  1  clear both error counters.
- chk_locked  out  1  checker in LOCKED.
- chk_bit_errs  out  CNT_W  saturating count of mismatched bits.
- chk_word_errs  out  CNT_W  saturating count of errored words.

## Operation
- LFSR step, shared by all paths: out[i] = s[0]; s ← {^(PRBS_POLY & {1'b0, s[PRBS_SIZE-2:0]}), s[PRBS_SIZE-1:1]}. Repeat DATA_WIDTH times per word.
- Property: bits [PRBS_SIZE-1:0] of a word equal the LFSR state at the start of that word.
- Generator priority, highest first:
  - gen_load: state ← seed (zero → PRBS_SEED); gen_valid ← 0; pending injection cleared.
  - Else if gen_en and (!gen_valid or gen_ready): gen_data ← word(state), with bit 0 inverted if an injection is pending; state ← advanced; gen_valid ← 1.
  - Else if !gen_en and gen_ready: gen_valid ← 0.
  - gen_data is held stable while gen_valid && !gen_ready.
- gen_inj_err sets a pending flag, cleared when the next word is produced. Multiple pulses before that word inject once.
- Checker FSM (acts only on chk_valid):
  - SEARCH:
    - Candidate seed = chk_data[PRBS_SIZE-1:0]. All-zero candidate → stay in SEARCH.
    - Otherwise: expected state ← advance(candidate); good count ← 0; → VERIFY.
  - VERIFY: compare chk_data with word(expected).
    - Match: good count +1; reaching LOCK_GOOD → LOCKED.
    - Mismatch: reseed from this word exactly as in SEARCH (reseeding may move back to SEARCH if the candidate is zero).
  - LOCKED: compare.
    - Mismatch: bit count += popcount(xor); word count +1; bad run +1; bad run reaching BAD_LIMIT → SEARCH.
    - Match: bad run ← 0.
  - Expected state advances on every valid word in VERIFY and LOCKED.
- Counters count only in LOCKED. Both saturate at 2^CNT_W−1.
- chk_clear has priority over any same-cycle increment; that cycle's increment is discarded. The FSM is unaffected by chk_clear.

## Timing
- Reset values:
  - gen_valid 0; gen_data 0; generator state PRBS_SEED.
  - FSM SEARCH; chk_locked 0; both counters 0; good count and bad run 0.
- Generator: first word valid one cycle after gen_en is sampled high.
- Checker outputs update one cycle after the word is accepted. chk_locked rises the cycle after the LOCK_GOOD-th match and falls the cycle after the BAD_LIMIT-th bad word.
- gen_load and chk behaviour are independent; the two halves share no state.
- rst_n mid-stream: all state returns to reset values at the next edge, and the in-flight word is dropped.

## Structure
- Package example_hmc_prbs_pkg: checker state enum (SEARCH, VERIFY, LOCKED); popcount function; saturating-add function.
- Sub-module example_hmc_prbs_step (combinational: state in → word out, next state out; PRBS_POLY/DATA_WIDTH/PRBS_SIZE parameters). Instantiated three times:
  - generator advance;
  - checker expected-word path;
  - checker reseed path.
- All registers live in example_hmc_prbs_engine.

## Test plan
- Loopback gen→chk, defaults, gen_ready=1: chk_locked rises the cycle after the 5th accepted word; counters stay 0 over 10^4 words.
- Locked, one gen_inj_err pulse: chk_bit_errs=1, chk_word_errs=1, chk_locked stays 1.
- Locked, 3 consecutive words each with 2 flipped bits: bit count 6, word count 3, chk_locked falls; relock 5 words later with counters held at 6/3.
- chk_data all zeros, 20 valid words: FSM stays in SEARCH, chk_locked 0, counters 0.
- gen_ready toggling 1,0,0,1 with gen_en=1: gen_data held across stalls; the checker still locks with zero errors.
- chk_clear coincident with an errored LOCKED word: counters read 0 next cycle. Separately, gen_seed=0 produces the same stream as PRBS_SEED.
